fc_seq_16_10: RTL and testbench
===============================

Name: fc_seq_16_10

Overview:
- Time-multiplexed sequencer for the 16-input, 10-output fully connected layer.
- Drives one shared neuron_16_10-style MAC serially over all 10 weight/bias sets instead of 10 parallel instances.
- Captures each 15-bit result and computes a running signed argmax (classification result).
- Sits between the last pooling/flatten stage (start_flag, in) and the result consumer (end_flag, class_idx).

Parameters:
- N_OUT, 10, number of output neurons sequenced.
- IN_W, 160, flattened input width (16 x 10 bits).
- OUT_W, 15, signed neuron result width.
- IDX_W, 4, width of the neuron index and class index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start_flag  in  1  one-cycle pulse; input vector valid.
- in  in  IN_W  flattened feature vector; sampled on start_flag.
- nrn_start  out  1  one-cycle launch pulse to the shared neuron.
- nrn_sel  out  IDX_W  weight/bias set index for the shared neuron.
- nrn_in  out  IN_W  latched feature vector to the shared neuron.
- nrn_out  in  OUT_W  shared neuron result, signed; valid when nrn_end=1.
- nrn_end  in  1  one-cycle done pulse from the shared neuron.
- out_flat  out  N_OUT*OUT_W  results; neuron k occupies bits [k*OUT_W +: OUT_W].
- class_idx  out  IDX_W  index of the maximum result.
- busy  out  1  high from the cycle after an accepted start until end_flag.
- end_flag  out  1  one-cycle pulse; out_flat and class_idx are valid.

Behaviour:
- Reset: all outputs 0, internal max/index registers 0, FSM=IDLE. A reset mid-operation aborts the run immediately with no end_flag, and any nrn_end after reset is ignored.
- FSM states and transitions:
  - IDLE: on start_flag, latch in into nrn_in, clear idx to 0, go to LAUNCH. busy rises the next cycle.
  - LAUNCH: nrn_start=1 for exactly one cycle, nrn_sel=idx, go to WAIT.
  - WAIT: hold nrn_sel. On nrn_end, register nrn_out into slot idx of out_flat and go to STORE.
  - STORE: update argmax. If idx==N_OUT-1 go to DONE; else idx++ and go to LAUNCH.
  - DONE: end_flag=1 for one cycle, class_idx <= best index, busy=0, go to IDLE.
- Argmax: signed OUT_W compare. idx 0 always loads max/best. A later result replaces the max only if strictly greater, so ties resolve to the lowest index.
- nrn_sel stays stable from LAUNCH through STORE of the same neuron. nrn_in stays stable for the whole run.
- nrn_end is honoured only in WAIT; it is ignored in all other states, including the LAUNCH cycle.
- start_flag is ignored while not in IDLE (no queueing, no restart).
- No timeout: WAIT holds indefinitely until nrn_end.
- Latency: with neuron latency L (cycles from nrn_start to nrn_end), run length = 1 + N_OUT*(L+2) cycles from the start_flag cycle to the end_flag cycle, inclusive of DONE.
- out_flat slots update progressively during a run. Slots not yet rewritten keep the previous run's values. class_idx changes only in DONE.

Test Plan:
- Single run with behavioural neuron model, L=4, results k*10 for k=0..9 → nrn_sel steps 0..9 with one nrn_start each; end_flag exactly 1+10*6=61 cycles after start; out_flat slot 9 = 90; class_idx=9.
- Negative results: slot 3 = -5, all others = -100 → class_idx=3, and out_flat holds correct two's-complement values.
- Tie: slots 2 and 7 both = 1234, all others lower → class_idx=2.
- start_flag pulsed again during WAIT of neuron 4 with a different in → ignored: nrn_in unchanged, no extra nrn_start, single end_flag.
- reset asserted during WAIT of neuron 5, then a spurious nrn_end → outputs all 0, no end_flag; a fresh start then completes a normal run.
- Variable neuron latency (L=1, then 9, then 3 per neuron) plus an nrn_end injected during LAUNCH → the stray pulse is ignored and the correct 10 results are captured in order.

Source files
------------

// File: rtl/fc_seq_16_10.sv
// fc_seq_16_10: time-multiplexed sequencer for the 16-input, 10-output fully
// connected layer. It launches one shared MAC neuron once for each of the 10
// weight/bias sets, in order. Each result goes into its slot of out_flat, and
// the block keeps a running signed argmax, which becomes the class index.
module fc_seq_16_10 #(
    parameter int N_OUT = 10,
    parameter int IN_W  = 160,
    parameter int OUT_W = 15,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_flag,
    input  logic [IN_W-1:0]        in,
    output logic                   nrn_start,
    output logic [IDX_W-1:0]       nrn_sel,
    output logic [IN_W-1:0]        nrn_in,
    input  logic [OUT_W-1:0]       nrn_out,
    input  logic                   nrn_end,
    output logic [N_OUT*OUT_W-1:0] out_flat,
    output logic [IDX_W-1:0]       class_idx,
    output logic                   busy,
    output logic                   end_flag
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_STORE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                   state_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic signed [OUT_W-1:0]  cur_reg;   // copy of the result being judged in STORE
    logic signed [OUT_W-1:0]  max_reg;
    logic [IDX_W-1:0]         best_reg;

    logic                     capture;
    logic                     is_new_max;
    logic [IDX_W-1:0]         best_next;
    logic                     last_neuron;

    // The neuron result is accepted only in WAIT. A done pulse in any other
    // state is ignored, including a stray one during LAUNCH.
    assign capture     = (state_reg == S_WAIT) && nrn_end;
    assign last_neuron = (idx_reg == IDX_W'(N_OUT - 1));

    // Neuron 0 always seeds the max. After that only a strictly greater
    // result wins, so ties go to the lowest index.
    always_comb begin
        is_new_max = (idx_reg == '0) || (cur_reg > max_reg);
        best_next  = is_new_max ? idx_reg : best_reg;
    end

    // One result register per output neuron. The slot is rewritten only when
    // its own neuron finishes, so slots that are not reached yet keep the
    // previous run's value.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_slot
            logic [OUT_W-1:0] slot_reg;

            // Capture the shared neuron's result when this slot is the active one
            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (capture && (idx_reg == IDX_W'(gi))) begin
                    slot_reg <= nrn_out;
                end
            end

            assign out_flat[gi*OUT_W +: OUT_W] = slot_reg;
        end
    endgenerate

    // Sequencer FSM. Each output is registered and set on the edge that
    // enters its state, so nrn_start is high during LAUNCH and end_flag is
    // high during DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            cur_reg   <= '0;
            max_reg   <= '0;
            best_reg  <= '0;
            nrn_start <= 1'b0;
            nrn_sel   <= '0;
            nrn_in    <= '0;
            class_idx <= '0;
            busy      <= 1'b0;
            end_flag  <= 1'b0;
        end else begin
            nrn_start <= 1'b0;
            end_flag  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_flag) begin
                        nrn_in    <= in;
                        idx_reg   <= '0;
                        nrn_sel   <= '0;
                        nrn_start <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture) begin
                        cur_reg   <= nrn_out;
                        state_reg <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (is_new_max) begin
                        max_reg  <= cur_reg;
                        best_reg <= idx_reg;
                    end
                    if (last_neuron) begin
                        // Publish the final winner together with end_flag.
                        class_idx <= best_next;
                        end_flag  <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        nrn_sel   <= idx_reg + 1'b1;
                        nrn_start <= 1'b1;
                        state_reg <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_seq_16_10.sv
// Testbench for fc_seq_16_10. It uses a behavioural shared neuron whose result
// and latency are set for each neuron index, and directed runs with
// hand-computed expectations.
module tb_fc_seq_16_10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_flag;
    logic [159:0] in;
    logic         nrn_start;
    logic [3:0]   nrn_sel;
    logic [159:0] nrn_in;
    logic [14:0]  nrn_out;
    logic         nrn_end;
    logic [149:0] out_flat;
    logic [3:0]   class_idx;
    logic         busy;
    logic         end_flag;

    fc_seq_16_10 dut (
        .clk        (clk),
        .reset      (reset),
        .start_flag (start_flag),
        .in         (in),
        .nrn_start  (nrn_start),
        .nrn_sel    (nrn_sel),
        .nrn_in     (nrn_in),
        .nrn_out    (nrn_out),
        .nrn_end    (nrn_end),
        .out_flat   (out_flat),
        .class_idx  (class_idx),
        .busy       (busy),
        .end_flag   (end_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Neuron model configuration, written by the main process between runs
    logic [14:0] res_tab [10];
    int          lat_tab [10];
    int          inj_sel = -1;     // neuron whose LAUNCH cycle gets a stray nrn_end

    // Model and monitor state, written only by the negedge process
    int          cyc = 0;
    int          start_cnt = 0;
    int          end_cnt = 0;
    int          start_cyc = 0;
    int          end_cyc = 0;
    logic [3:0]  sel_log [64];
    logic [149:0] cap_flat;
    logic [3:0]  cap_class;
    int          pend = 0;
    int          cnt = 0;
    logic [3:0]  msel;

    initial begin
        nrn_end = 1'b0;
        nrn_out = '0;
    end

    // Behavioural neuron: nrn_end is seen by the DUT exactly L cycles after
    // nrn_start. Every sampling happens on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        nrn_end = 1'b0;
        if (pend != 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                nrn_end = 1'b1;
                nrn_out = res_tab[msel];
                pend = 0;
            end
        end
        if (nrn_start) begin
            sel_log[start_cnt % 64] = nrn_sel;
            start_cnt = start_cnt + 1;
            msel = nrn_sel;
            cnt  = lat_tab[nrn_sel];
            pend = 1;
            if (int'(nrn_sel) == inj_sel) begin
                nrn_end = 1'b1;
                nrn_out = 15'h2AAA;
            end
        end
        if (start_flag && !busy)
            start_cyc = cyc;
        if (end_flag) begin
            end_cnt   = end_cnt + 1;
            end_cyc   = cyc;
            cap_flat  = out_flat;
            cap_class = class_idx;
        end
    end

    function automatic logic [149:0] pack_res();
        logic [149:0] v;
        v = '0;
        for (int k = 0; k < 10; k++) v[k*15 +: 15] = res_tab[k];
        return v;
    endfunction

    int run_s0;
    int run_e0;

    task automatic launch(input logic [159:0] vec);
        run_s0 = start_cnt;
        run_e0 = end_cnt;
        @(posedge clk); #1;
        start_flag = 1'b1;
        in = vec;
        @(posedge clk); #1;
        start_flag = 1'b0;
    endtask

    task automatic wait_sel_wait(input logic [3:0] s);
        int n;
        n = 0;
        while (!(busy && nrn_sel == s && !nrn_start) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic finish_run(input string tag, input logic [159:0] vec, input int exp_len,
                              input logic [3:0] exp_class);
        logic [39:0] seq;
        int n;
        n = 0;
        while (end_cnt == run_e0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " end_count"}, end_cnt - run_e0, 1);
        check({tag, " length"}, end_cyc - start_cyc, exp_len);
        check({tag, " starts"}, start_cnt - run_s0, 10);
        seq = '0;
        for (int k = 0; k < 10; k++) seq[k*4 +: 4] = sel_log[(run_s0 + k) % 64];
        check({tag, " sel_seq"}, seq, 40'h9876543210);
        check({tag, " out_flat"}, cap_flat, pack_res());
        check({tag, " class_idx"}, cap_class, exp_class);
        check({tag, " nrn_in"}, nrn_in, vec);
        check({tag, " busy_after"}, busy, 0);
    endtask

    localparam logic [159:0] VEC_A = {5{32'hDEADBEEF}};
    localparam logic [159:0] VEC_B = {5{32'h12345678}};
    localparam logic [159:0] VEC_C = {5{32'h0F1E2D3C}};

    initial begin
        reset = 1'b1;
        start_flag = 1'b0;
        in = '0;
        for (int k = 0; k < 10; k++) begin
            res_tab[k] = '0;
            lat_tab[k] = 4;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("reset ctrl", {nrn_start, nrn_sel, busy, end_flag, class_idx}, 0);
        check("reset out_flat", out_flat, 0);
        check("reset nrn_in", nrn_in, 0);

        // Run 1: results k*10, L=4, so the run is 1+10*6 = 61 cycles
        for (int k = 0; k < 10; k++) res_tab[k] = 15'(k * 10);
        launch(VEC_A);
        check("run1 busy_rise", busy, 1);
        finish_run("run1", VEC_A, 61, 4'd9);
        check("run1 slot9", cap_flat[135 +: 15], 15'd90);

        // Run 2: slot 3 = -5, all others -100
        for (int k = 0; k < 10; k++) res_tab[k] = 15'h7F9C;
        res_tab[3] = 15'h7FFB;
        launch(VEC_B);
        repeat (5) @(posedge clk);
        #1 check("run2 class_hold", class_idx, 4'd9);
        finish_run("run2", VEC_B, 61, 4'd3);
        check("run2 slot3", cap_flat[45 +: 15], 15'h7FFB);
        check("run2 slot0", cap_flat[0 +: 15], 15'h7F9C);

        // Run 3: tie between slots 2 and 7 goes to the lower index
        for (int k = 0; k < 10; k++) res_tab[k] = 15'(k * 10);
        res_tab[2] = 15'd1234;
        res_tab[7] = 15'd1234;
        launch(VEC_C);
        finish_run("run3", VEC_C, 61, 4'd2);

        // Run 4: a second start_flag during WAIT of neuron 4 is ignored
        for (int k = 0; k < 10; k++) res_tab[k] = 15'(k * 10);
        launch(VEC_A);
        wait_sel_wait(4'd4);
        start_flag = 1'b1;
        in = VEC_B;
        @(posedge clk); #1;
        start_flag = 1'b0;
        finish_run("run4", VEC_A, 61, 4'd9);
        repeat (20) @(posedge clk);
        #1 check("run4 no_restart", {start_cnt - run_s0, end_cnt - run_e0}, {32'd10, 32'd1});

        // Run 5: reset during WAIT of neuron 5; the pending neuron done arrives after reset
        launch(VEC_C);
        wait_sel_wait(4'd5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort end_count", end_cnt - run_e0, 0);
        check("abort out_flat", out_flat, 0);
        check("abort ctrl", {nrn_start, nrn_sel, busy, end_flag, class_idx}, 0);
        check("abort nrn_in", nrn_in, 0);
        for (int k = 0; k < 10; k++) res_tab[k] = 15'(k);
        res_tab[4] = 15'd777;
        launch(VEC_B);
        finish_run("fresh", VEC_B, 61, 4'd4);

        // Run 6: latencies 1,9,3 repeating, plus a stray nrn_end in LAUNCH of neuron 3.
        // The latencies sum to 40, so the run is 40 + 20 + 1 = 61 cycles.
        for (int k = 0; k < 10; k++) begin
            res_tab[k] = 15'(k) - 15'd50;
            lat_tab[k] = (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 9 : 3);
        end
        res_tab[6] = 15'd500;
        inj_sel = 3;
        launch(VEC_C);
        finish_run("varlat", VEC_C, 61, 4'd6);
        inj_sel = -1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
